// File: rtl/crc_frame_chk.sv
// crc_frame_chk: accumulates a bit-serial-equivalent CRC over a fixed-length beat frame
// and reports checksum/framing errors with a saturating error counter.
`default_nettype none

module crc_frame_chk #(
  parameter int                   BEAT_WIDTH = 128,
  parameter int                   CRC_WIDTH  = 32,
  parameter int                   NUM_BEATS  = 4,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY   = 32'h04C11DB7,
  parameter logic [CRC_WIDTH-1:0] CRC_INIT   = '0,
  parameter int                   CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [BEAT_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic [CRC_WIDTH-1:0]  checksum_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  detected_o,
  output logic                  frame_err_o,
  output logic [CRC_WIDTH-1:0]  crc_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);

  localparam int IDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     beat_idx;
  logic [CRC_WIDTH-1:0] crc_q;
  logic [CRC_WIDTH-1:0] crc_base;
  logic [CRC_WIDTH-1:0] crc_new;
  logic                 accept;
  logic                 at_last_idx;
  logic                 closing;
  logic                 frame_err_nxt;
  logic                 result_take;

  // Whole-beat CRC unrolled from the MSB down, one polynomial step per bit.
  function automatic logic [CRC_WIDTH-1:0] crc_update(
    input logic [CRC_WIDTH-1:0]  crc_in,
    input logic [BEAT_WIDTH-1:0] data
  );
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = crc_in;
    for (int i = BEAT_WIDTH - 1; i >= 0; i--) begin
      fb = c[CRC_WIDTH-1] ^ data[i];
      c  = (c << 1) ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

  assign ready_o       = (state != RESULT);
  assign valid_o       = (state == RESULT);
  assign accept        = valid_i & ready_o;
  assign result_take   = valid_o & ready_i;
  assign at_last_idx   = (beat_idx == LAST_IDX);
  assign closing       = accept & (last_i | at_last_idx);
  // Early last_i and a missing last_i on the final index are both framing errors.
  assign frame_err_nxt = last_i ^ at_last_idx;
  assign crc_base      = (state == IDLE) ? CRC_INIT : crc_q;
  assign crc_new       = crc_update(crc_base, data_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = closing ? RESULT : ACCUM;
        end
      end
      ACCUM: begin
        if (closing) begin
          state_nxt = RESULT;
        end
      end
      RESULT: begin
        if (ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx    <= '0;
      crc_q       <= CRC_INIT;
      crc_o       <= '0;
      detected_o  <= 1'b0;
      frame_err_o <= 1'b0;
      err_cnt_o   <= '0;
    end else begin
      if (accept) begin
        if (closing) begin
          crc_o       <= crc_new;
          frame_err_o <= frame_err_nxt;
          detected_o  <= (crc_new != checksum_i) | frame_err_nxt;
          beat_idx    <= '0;
          crc_q       <= CRC_INIT;
        end else begin
          crc_q    <= crc_new;
          beat_idx <= beat_idx + IDX_W'(1);
        end
      end
      if (result_take) begin
        beat_idx <= '0;
        if (detected_o && (err_cnt_o != {CNT_WIDTH{1'b1}})) begin
          err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
